// File: rtl/arp_pkg.sv
// arp_pkg: ARP protocol constants and resolver state encoding shared by the
// resolver top and its request serializer.
package arp_pkg;

    localparam logic [15:0] ETHERTYPE_ARP = 16'h0806;
    localparam logic [15:0] HTYPE_ETH     = 16'h0001;
    localparam logic [15:0] PTYPE_IPV4    = 16'h0800;
    localparam logic [7:0]  HLEN_ETH      = 8'h06;
    localparam logic [7:0]  PLEN_IPV4     = 8'h04;
    localparam logic [15:0] OPER_REQUEST  = 16'h0001;
    localparam logic [15:0] OPER_REPLY    = 16'h0002;
    localparam logic [47:0] BCAST_MAC     = 48'hFFFF_FFFF_FFFF;

    // Index of the final byte of the 28-byte ARP request payload.
    localparam logic [4:0]  ARP_LAST_IDX  = 5'd27;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } arp_state_e;

endpackage

// File: rtl/arp_req_tx.sv
// arp_req_tx: serializes the 28-byte ARP request payload MSB first. A byte
// is presented on tx_data while tx_valid is high and advances only when the
// encoder takes it with tx_next.
module arp_req_tx
    import arp_pkg::*;
#(
    parameter logic [47:0] SHA = 48'hDEADBEEFCAFE,
    parameter logic [31:0] SPA = 32'h69696969
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] tpa,
    input  logic        tx_next,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        last
);

    logic [223:0] frame_s;
    logic [4:0]   idx_q;
    logic         busy_q;
    logic [7:0]   data_q;

    // Picks byte idx (0 = first on the wire) out of the packed payload.
    function automatic logic [7:0] frame_byte(input logic [223:0] frame,
                                              input logic [4:0]   idx);
        logic [7:0] off;
        off = {5'(ARP_LAST_IDX - idx), 3'b000};
        return frame[off +: 8];
    endfunction

    assign frame_s = {HTYPE_ETH, PTYPE_IPV4, HLEN_ETH, PLEN_IPV4, OPER_REQUEST,
                      SHA, SPA, 48'h0000_0000_0000, tpa};

    // Byte pointer and output register; data only moves on a taken byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            idx_q  <= 5'd0;
            data_q <= 8'h00;
        end else if (start) begin
            busy_q <= 1'b1;
            idx_q  <= 5'd0;
            data_q <= frame_byte(frame_s, 5'd0);
        end else if (busy_q && tx_next) begin
            if (idx_q == ARP_LAST_IDX) begin
                busy_q <= 1'b0;
                idx_q  <= 5'd0;
                data_q <= 8'h00;
            end else begin
                idx_q  <= idx_q + 5'd1;
                data_q <= frame_byte(frame_s, idx_q + 5'd1);
            end
        end
    end

    assign tx_valid = busy_q;
    assign tx_data  = data_q;
    assign last     = busy_q && (idx_q == ARP_LAST_IDX);

endmodule

// File: rtl/arp_resolver.sv
// arp_resolver: resolves an IPv4 address to a MAC by broadcasting an ARP
// request, waiting for the matching reply, and retransmitting on timeout.
// Build macro ARP_RESOLVER_CACHE_EN adds a single-entry result cache that
// answers a repeated request without touching the wire.
module arp_resolver
    import arp_pkg::*;
#(
    parameter logic [47:0] MAC_ADDR       = 48'hDEADBEEFCAFE,
    parameter logic [31:0] IP_ADDR        = 32'h69696969,
    parameter int          TIMEOUT_CYCLES = 125000000,
    parameter int          MAX_RETRIES    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [31:0] req_ip,
    output logic        req_ready,
    output logic        res_valid,
    output logic        res_err,
    output logic [47:0] res_mac,
    output logic        tx_start,
    output logic [47:0] tx_dest,
    output logic [15:0] tx_ethertype,
    input  logic        tx_next,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        rx_done,
    input  logic [47:0] rx_sha,
    input  logic [31:0] rx_spa,
    input  logic [47:0] rx_tha
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int RTY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

    arp_state_e       state_q;
    logic [31:0]      ip_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [RTY_W-1:0] rty_q;
    logic             req_ready_q;
    logic             res_valid_q;
    logic             res_err_q;
    logic [47:0]      res_mac_q;
    logic             tx_start_q;

    logic             accept_s;
    logic             hit_s;
    logic [47:0]      cache_mac_s;
    logic             match_s;
    logic             expire_s;
    logic             retry_s;
    logic             start_s;
    logic             frame_end_s;
    logic             ser_valid_s;
    logic             ser_last_s;

    assign accept_s    = req_valid && req_ready_q;
    assign match_s     = (state_q == ST_WAIT) && rx_done &&
                         (rx_spa == ip_q) && (rx_tha == MAC_ADDR);
    // The wait expires in the cycle the counter steps down to zero, so the
    // last payload byte is followed by exactly TIMEOUT_CYCLES cycles before
    // the retransmission or the error result appears.
    assign expire_s    = (state_q == ST_WAIT) && (cnt_q <= CNT_W'(1));
    assign retry_s     = expire_s && !match_s && (rty_q < RTY_MAX);
    assign start_s     = (accept_s && !hit_s) || retry_s;
    assign frame_end_s = tx_next && ser_valid_s && ser_last_s;

    arp_req_tx #(
        .SHA (MAC_ADDR),
        .SPA (IP_ADDR)
    ) u_req_tx (
        .clk      (clk),
        .rst      (rst),
        .start    (start_s),
        .tpa      (ip_q),
        .tx_next  (tx_next),
        .tx_valid (ser_valid_s),
        .tx_data  (tx_data),
        .last     (ser_last_s)
    );

`ifdef ARP_RESOLVER_CACHE_EN
    logic [31:0] cache_ip_q;
    logic [47:0] cache_mac_q;
    logic        cache_vld_q;

    // Remember the most recent successful resolution.
    always_ff @(posedge clk) begin
        if (rst) begin
            cache_vld_q <= 1'b0;
            cache_ip_q  <= 32'h0000_0000;
            cache_mac_q <= 48'h0000_0000_0000;
        end else if (match_s) begin
            cache_vld_q <= 1'b1;
            cache_ip_q  <= ip_q;
            cache_mac_q <= rx_sha;
        end
    end

    assign hit_s       = cache_vld_q && (cache_ip_q == req_ip);
    assign cache_mac_s = cache_mac_q;
`else
    assign hit_s       = 1'b0;
    assign cache_mac_s = 48'h0000_0000_0000;
`endif

    // Timeout counter next value: reload at end of frame, count down in WAIT, hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (frame_end_s) begin
            cnt_d = CNT_LOAD;
        end else if ((state_q == ST_WAIT) && (cnt_q != {CNT_W{1'b0}})) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Resolver FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ip_q        <= 32'h0000_0000;
            cnt_q       <= {CNT_W{1'b0}};
            rty_q       <= {RTY_W{1'b0}};
            req_ready_q <= 1'b1;
            res_valid_q <= 1'b0;
            res_err_q   <= 1'b0;
            res_mac_q   <= 48'h0000_0000_0000;
            tx_start_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            tx_start_q  <= start_s;
            res_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        ip_q        <= req_ip;
                        rty_q       <= {RTY_W{1'b0}};
                        req_ready_q <= 1'b0;
                        if (hit_s) begin
                            // Cached answer: DONE raises res_valid one cycle later.
                            state_q   <= ST_DONE;
                            res_err_q <= 1'b0;
                            res_mac_q <= cache_mac_s;
                        end else begin
                            state_q <= ST_SEND;
                        end
                    end
                end
                ST_SEND: begin
                    if (frame_end_s) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (match_s) begin
                        state_q     <= ST_DONE;
                        res_valid_q <= 1'b1;
                        res_err_q   <= 1'b0;
                        res_mac_q   <= rx_sha;
                    end else if (retry_s) begin
                        state_q <= ST_SEND;
                        rty_q   <= rty_q + RTY_W'(1);
                    end else if (expire_s) begin
                        state_q     <= ST_DONE;
                        res_valid_q <= 1'b1;
                        res_err_q   <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (res_valid_q) begin
                        state_q     <= ST_IDLE;
                        req_ready_q <= 1'b1;
                    end else begin
                        res_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready    = req_ready_q;
    assign res_valid    = res_valid_q;
    assign res_err      = res_err_q;
    assign res_mac      = res_mac_q;
    assign tx_start     = tx_start_q;
    assign tx_valid     = ser_valid_s;
    assign tx_dest      = BCAST_MAC;
    assign tx_ethertype = ETHERTYPE_ARP;

endmodule

// File: tb/tb_arp_resolver.sv
// tb_arp_resolver: directed bench. Instance 0 uses default parameters,
// instance 1 uses TIMEOUT_CYCLES=50, MAX_RETRIES=2 for the timeout paths.
module tb_arp_resolver;

    localparam logic [47:0] LOC_MAC  = 48'hDEADBEEFCAFE;
    localparam logic [31:0] LOC_IP   = 32'h69696969;
    localparam logic [47:0] PEER_MAC = 48'h112233445566;
    localparam logic [31:0] PEER_IP  = 32'h0A000001;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx_next;
    logic [31:0] req_ip;
    logic [47:0] rx_sha;
    logic [31:0] rx_spa;
    logic [47:0] rx_tha;

    logic        req_valid [2];
    logic        rx_done   [2];
    logic        req_ready [2];
    logic        res_valid [2];
    logic        res_err   [2];
    logic [47:0] res_mac   [2];
    logic        tx_start  [2];
    logic [47:0] tx_dest   [2];
    logic [15:0] tx_type   [2];
    logic        tx_valid  [2];
    logic [7:0]  tx_data   [2];

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  cap [28];

    always #5 clk = ~clk;

    arp_resolver u_dut_a (
        .clk (clk), .rst (rst),
        .req_valid (req_valid[0]), .req_ip (req_ip), .req_ready (req_ready[0]),
        .res_valid (res_valid[0]), .res_err (res_err[0]), .res_mac (res_mac[0]),
        .tx_start (tx_start[0]), .tx_dest (tx_dest[0]), .tx_ethertype (tx_type[0]),
        .tx_next (tx_next), .tx_valid (tx_valid[0]), .tx_data (tx_data[0]),
        .rx_done (rx_done[0]), .rx_sha (rx_sha), .rx_spa (rx_spa), .rx_tha (rx_tha)
    );

    arp_resolver #(.TIMEOUT_CYCLES(50), .MAX_RETRIES(2)) u_dut_b (
        .clk (clk), .rst (rst),
        .req_valid (req_valid[1]), .req_ip (req_ip), .req_ready (req_ready[1]),
        .res_valid (res_valid[1]), .res_err (res_err[1]), .res_mac (res_mac[1]),
        .tx_start (tx_start[1]), .tx_dest (tx_dest[1]), .tx_ethertype (tx_type[1]),
        .tx_next (tx_next), .tx_valid (tx_valid[1]), .tx_data (tx_data[1]),
        .rx_done (rx_done[1]), .rx_sha (rx_sha), .rx_spa (rx_spa), .rx_tha (rx_tha)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected payload byte i for target address tpa, hand-assembled.
    function automatic logic [7:0] exp_byte(input int i, input logic [31:0] tpa);
        logic [223:0] f;
        f = {64'h0001_0800_0604_0001, LOC_MAC, LOC_IP, 48'h0000_0000_0000, tpa};
        return f[223 - 8*i -: 8];
    endfunction

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Presents a request for one cycle; returns in the cycle after acceptance.
    task automatic issue(input int k, input logic [31:0] ip);
        req_ip       = ip;
        req_valid[k] = 1'b1;
        @(negedge clk);
        req_valid[k] = 1'b0;
    endtask

    // Captures a frame starting in the current cycle; returns in the cycle
    // where byte 27 is on the bus (tx_next is held high).
    task automatic take_frame(input int k, input logic [31:0] ip, input string tg);
        int n;
        int guard;
        n = 0;
        guard = 0;
        check($sformatf("%s tx_start", tg), 64'(tx_start[k]), 64'd1);
        forever begin
            if (tx_valid[k]) begin
                cap[n] = tx_data[k];
                n++;
            end
            if (n == 28 || guard == 60) break;
            @(negedge clk);
            guard++;
        end
        check($sformatf("%s nbytes", tg), 64'(n), 64'd28);
        for (int i = 0; i < 28; i++)
            check($sformatf("%s b%0d", tg, i), 64'(cap[i]), 64'(exp_byte(i, ip)));
    endtask

    // Counts cycles until tx_start (sel=0) or res_valid (sel=1) of instance k.
    task automatic cycles_until(input int k, input bit sel, output int cnt, output int starts);
        cnt = 0;
        starts = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (tx_start[k]) starts++;
        end while (!(sel ? res_valid[k] : tx_start[k]) && cnt < 200);
    endtask

    initial begin
        int cnt;
        int starts;
        rst = 1'b1; tx_next = 1'b1; req_ip = 32'h0;
        rx_sha = 48'h0; rx_spa = 32'h0; rx_tha = 48'h0;
        req_valid[0] = 1'b0; req_valid[1] = 1'b0;
        rx_done[0] = 1'b0;   rx_done[1] = 1'b0;
        cycles(3);
        rst = 1'b0;

        // Reset values on both instances.
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst%0d req_ready", k), 64'(req_ready[k]), 64'd1);
            check($sformatf("rst%0d res_valid", k), 64'(res_valid[k]), 64'd0);
            check($sformatf("rst%0d res_err", k),   64'(res_err[k]),   64'd0);
            check($sformatf("rst%0d res_mac", k),   64'(res_mac[k]),   64'd0);
            check($sformatf("rst%0d tx_start", k),  64'(tx_start[k]),  64'd0);
            check($sformatf("rst%0d tx_valid", k),  64'(tx_valid[k]),  64'd0);
            check($sformatf("rst%0d tx_data", k),   64'(tx_data[k]),   64'd0);
            check($sformatf("rst%0d tx_dest", k),   64'(tx_dest[k]),   64'hFFFF_FFFF_FFFF);
            check($sformatf("rst%0d ethertype", k), 64'(tx_type[k]),   64'h0806);
        end

        // rx_done while idle is ignored (this would match ip_q=0 in WAIT).
        rx_done[0] = 1'b1; rx_spa = 32'h0; rx_tha = LOC_MAC; rx_sha = PEER_MAC;
        @(negedge clk);
        rx_done[0] = 1'b0;
        check("idle_rx res_valid", 64'(res_valid[0]), 64'd0);
        check("idle_rx req_ready", 64'(req_ready[0]), 64'd1);

        // Resolve 10.0.0.1, reply 100 cycles after the last byte.
        issue(0, PEER_IP);
        check("f1 req_ready", 64'(req_ready[0]), 64'd0);
        take_frame(0, PEER_IP, "f1");
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i == 0) check("f1 tx_valid_drop", 64'(tx_valid[0]), 64'd0);
            if (i == 10) begin
                req_ip = 32'h0A0000FF;
                req_valid[0] = 1'b1;
            end
            if (i == 11) begin
                req_valid[0] = 1'b0;
                check("busy_req tx_start", 64'(tx_start[0]), 64'd0);
            end
        end
        check("f1 pre res_valid", 64'(res_valid[0]), 64'd0);
        rx_done[0] = 1'b1; rx_sha = PEER_MAC; rx_spa = PEER_IP; rx_tha = LOC_MAC;
        @(negedge clk);
        rx_done[0] = 1'b0;
        check("f1 res_valid", 64'(res_valid[0]), 64'd1);
        check("f1 res_err",   64'(res_err[0]),   64'd0);
        check("f1 res_mac",   64'(res_mac[0]),   64'(PEER_MAC));
        @(negedge clk);
        check("f1 res_pulse", 64'(res_valid[0]), 64'd0);
        check("f1 ready",     64'(req_ready[0]), 64'd1);

        // Reset while byte 10 is on the bus.
        issue(0, 32'h0A000002);
        cycles(10);
        check("rst10 byte", 64'(tx_data[0]), 64'hBE);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst10 tx_valid", 64'(tx_valid[0]), 64'd0);
        check("rst10 ready",    64'(req_ready[0]), 64'd1);
        check("rst10 tx_data",  64'(tx_data[0]),   64'd0);
        @(negedge clk);
        check("rst10 quiet", 64'(tx_valid[0]), 64'd0);

        // Fresh request after reset sends a full frame (cache, if any, was cleared).
        issue(0, PEER_IP);
        take_frame(0, PEER_IP, "f2");
        @(negedge clk);
        rx_done[0] = 1'b1; rx_sha = 48'hA1B2C3D4E5F6; rx_spa = PEER_IP; rx_tha = LOC_MAC;
        @(negedge clk);
        rx_done[0] = 1'b0;
        check("f2 res_valid", 64'(res_valid[0]), 64'd1);
        check("f2 res_mac",   64'(res_mac[0]),   64'hA1B2C3D4E5F6);
        @(negedge clk);

        // Repeat request for the same address.
        issue(0, PEER_IP);
`ifdef ARP_RESOLVER_CACHE_EN
        check("hit tx_start",  64'(tx_start[0]),  64'd0);
        check("hit tx_valid",  64'(tx_valid[0]),  64'd0);
        check("hit early",     64'(res_valid[0]), 64'd0);
        @(negedge clk);
        check("hit res_valid", 64'(res_valid[0]), 64'd1);
        check("hit res_err",   64'(res_err[0]),   64'd0);
        check("hit res_mac",   64'(res_mac[0]),   64'hA1B2C3D4E5F6);
        @(negedge clk);
        check("hit pulse",     64'(res_valid[0]), 64'd0);
        check("hit ready",     64'(req_ready[0]), 64'd1);
`else
        take_frame(0, PEER_IP, "f3");
`endif

        // Instance 1: no reply -> 3 frames, then error result.
        issue(1, PEER_IP);
        take_frame(1, PEER_IP, "t1");
        cycles_until(1, 1'b0, cnt, starts);
        check("t1 retry_gap", 64'(cnt), 64'd50);
        take_frame(1, PEER_IP, "t2");
        cycles_until(1, 1'b0, cnt, starts);
        check("t2 retry_gap", 64'(cnt), 64'd50);
        take_frame(1, PEER_IP, "t3");
        cycles_until(1, 1'b1, cnt, starts);
        check("t3 err_gap",   64'(cnt),         64'd50);
        check("t3 no_4th",    64'(starts),      64'd0);
        check("t3 res_err",   64'(res_err[1]),  64'd1);
        @(negedge clk);
        check("t3 pulse",     64'(res_valid[1]), 64'd0);
        check("t3 ready",     64'(req_ready[1]), 64'd1);

        // Wrong-IP reply ignored; correct reply on the expiry cycle wins.
        issue(1, PEER_IP);
        take_frame(1, PEER_IP, "m1");
        cycles(5);
        rx_done[1] = 1'b1; rx_sha = 48'h0; rx_spa = 32'h0A000009; rx_tha = LOC_MAC;
        @(negedge clk);
        rx_done[1] = 1'b0;
        check("m1 wrong res_valid", 64'(res_valid[1]), 64'd0);
        check("m1 wrong tx_start",  64'(tx_start[1]),  64'd0);
        cycles(43);
        rx_done[1] = 1'b1; rx_sha = 48'h665544332211; rx_spa = PEER_IP; rx_tha = LOC_MAC;
        @(negedge clk);
        rx_done[1] = 1'b0;
        check("m1 res_valid", 64'(res_valid[1]), 64'd1);
        check("m1 res_err",   64'(res_err[1]),   64'd0);
        check("m1 res_mac",   64'(res_mac[1]),   64'h665544332211);
        check("m1 no_retry",  64'(tx_start[1]),  64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/arp_resolver.md
ARP_RESOLVER -- requirements
Module: arp_resolver

Interface
REQ-001 SHALL have parameter MAC_ADDR, default 48'hDEADBEEFCAFE, local hardware address placed in SHA.
REQ-002 SHALL have parameter IP_ADDR, default 32'h69696969, local protocol address placed in SPA.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 125000000, the reply wait per attempt in clk cycles.
REQ-004 SHALL have parameter MAX_RETRIES, default 3, the number of retransmissions after the first attempt.
REQ-005 SHALL have ports:
 clk  in  1  clock; all ports synchronous to it
 rst  in  1  reset, synchronous, active-high
 req_valid  in  1  resolve request
 req_ip  in  32  target IP
 req_ready  out  1  high only in IDLE
 res_valid  out  1  one-cycle result pulse
 res_err  out  1  with res_valid: 1=timeout, 0=resolved
 res_mac  out  48  resolved MAC, valid with res_valid && !res_err
 tx_start  out  1  one-cycle pulse to frame encoder
 tx_dest  out  48  constant 48'hFFFFFFFFFFFF
 tx_ethertype  out  16  constant 16'h0806
 tx_next  in  1  encoder requests a payload byte
 tx_valid  out  1  payload byte available
 tx_data  out  8  payload byte
 rx_done  in  1  ARP decode complete, one-cycle pulse, CRC-checked
 rx_sha  in  48  decoded sender MAC
 rx_spa  in  32  decoded sender IP
 rx_tha  in  48  decoded target MAC

Function
REQ-006 SHALL implement states IDLE, SEND, WAIT, DONE.
REQ-007 IDLE: req_valid && req_ready latches req_ip, clears the retry count, and enters SEND; tx_start SHALL pulse in the next cycle.
REQ-008 SEND: tx_valid SHALL be high while bytes remain; a byte is consumed on a cycle with tx_next && tx_valid; tx_data SHALL change only on consumption.
REQ-009 Payload SHALL be 28 bytes, MSB first: 0001, 0800, 06, 04, 0001, MAC_ADDR, IP_ADDR, 000000000000, latched req_ip.
REQ-010 After byte 27 is consumed: tx_valid low the next cycle; enter WAIT; load the timeout counter with TIMEOUT_CYCLES-1.
REQ-011 WAIT: a reply matches when rx_done && rx_spa==latched ip && rx_tha==MAC_ADDR. On a match: latch rx_sha and go to DONE with res_err=0.
REQ-012 WAIT: when the counter reaches 0 and no match occurs that cycle, go to SEND (new tx_start) if retries<MAX_RETRIES and increment retries; otherwise go to DONE with res_err=1.
REQ-013 A match and a timeout in the same cycle SHALL resolve as a match.
REQ-014 rx_done outside WAIT SHALL be ignored; req_valid outside IDLE SHALL be ignored.
REQ-015 DONE: res_valid SHALL be high for exactly one cycle, then the block returns to IDLE; match-to-res_valid latency is 1 cycle.
REQ-016 MAX_RETRIES=0 SHALL give exactly one transmission.
REQ-017 The counter SHALL be $clog2(TIMEOUT_CYCLES) bits wide, saturating at 0, with no wrap.

Reset
REQ-018 rst SHALL force IDLE. Reset values: req_ready=1; res_valid, res_err, tx_start, tx_valid = 0; tx_data=0; res_mac=0; retry count 0.
REQ-019 rst mid-frame SHALL drop tx_valid the next cycle, with no further bytes.

Configuration
REQ-020 With ARP_RESOLVER_CACHE_EN defined, the block SHALL keep a single-entry {ip, mac, valid} cache written on every successful resolve.
REQ-021 With ARP_RESOLVER_CACHE_EN defined, a request whose req_ip hits a valid cache entry SHALL skip SEND/WAIT and produce res_valid, res_err=0 and the cached MAC 2 cycles after acceptance.
REQ-022 With ARP_RESOLVER_CACHE_EN defined, rst SHALL clear the cache valid bit.
REQ-023 Without ARP_RESOLVER_CACHE_EN, no cache storage SHALL exist and every request SHALL transmit.

Structure
REQ-024 Shared package arp_pkg SHALL hold ETHERTYPE_ARP, HTYPE_ETH, PTYPE_IPV4, OPER_REQUEST, OPER_REPLY, BCAST_MAC and the resolver state enum.
REQ-025 The 28-byte serializer SHALL be sub-module arp_req_tx (inputs: start, tpa, tx_next; outputs: tx_valid, tx_data, last).

Verification
REQ-026 Bench: req_ip=0x0A000001, tx_next always high -> tx_start 1 cycle after accept; 28 bytes in order; byte 24..27 = 0A 00 00 01.
REQ-027 Bench: matching reply (rx_sha=0x112233445566) 100 cycles after the last byte -> res_valid next cycle, res_err=0, res_mac=0x112233445566.
REQ-028 Bench: TIMEOUT_CYCLES=50, MAX_RETRIES=2, no reply -> 3 frames sent, then res_valid with res_err=1 exactly 50 cycles after the third frame's last byte.
REQ-029 Bench: reply with a wrong rx_spa, then rx_done in the same cycle the counter hits 0 with a correct reply -> no action on the first; match resolves on the second with res_err=0.
REQ-030 Bench: rst asserted at byte 10 -> tx_valid low next cycle; req_ready=1; a new request sends a full frame from byte 0.
REQ-031 Bench (ARP_RESOLVER_CACHE_EN defined): resolve 0x0A000001, repeat the request -> no tx_start; res_valid 2 cycles after accept with the cached MAC.
